hawk_att_lkup_rsp: RTL

HAWK_ATT_LKUP_RSP -- requirements
Module: hawk_att_lkup_rsp

---
 rtl/hacd_pkg.sv | 73 +++++++
 rtl/hawk_att_lkup_rsp.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hacd_pkg.sv
// Shared types and helpers for the HACD address-translation path: ATT entry layout,
// lookup/translation packets and the AXI read-channel packets.
package hacd_pkg;

  localparam int unsigned HACD_AXI4_ADDR_WIDTH = 64;
  localparam int unsigned HACD_AXI4_DATA_WIDTH = 512;
  localparam logic [63:0] HAWK_ATT_START       = 64'h0000_0000_8000_0000;
  localparam logic [63:0] HPPA_BASE_ADDR       = 64'h0000_0001_0000_0000;
  localparam int unsigned ATT_ENTRY_MAX        = 1024;
  localparam int unsigned ATT_ENTRY_CNT        = 512;

  localparam logic [1:0] STS_DALLOC = 2'b00;
  localparam logic [1:0] STS_UNCOMP = 2'b01;

  typedef struct packed {
    logic [7:0]  zpd_cnt;
    logic [53:0] way;
    logic [1:0]  sts;
  } AttEntry;

  typedef struct packed {
    logic                               lookup;
    logic [HACD_AXI4_ADDR_WIDTH-13:0]   hppa;
    logic                               zeroBlkWr;
  } att_lkup_reqpkt_t;

  typedef struct packed {
    logic                            allow_access;
    logic [1:0]                      sts;
    logic [HACD_AXI4_ADDR_WIDTH-1:0] ppa;
    logic                            zpd_update;
    logic [7:0]                      zpd_cnt;
  } trnsl_reqpkt_t;

  typedef struct packed {
    logic [HACD_AXI4_ADDR_WIDTH-1:0] addr;
    logic [7:0]                      arlen;
    logic                            arvalid;
    logic                            rready;
  } axi_rd_reqpkt_t;

  typedef struct packed {
    logic arready;
  } axi_rd_rdypkt_t;

  typedef struct packed {
    logic [1:0]                      rresp;
    logic [HACD_AXI4_DATA_WIDTH-1:0] rdata;
    logic                            rvalid;
    logic                            rlast;
  } axi_rd_resppkt_t;

  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Reverse byte order inside every 64-bit lane (memory is big-endian per entry).
  function automatic logic [HACD_AXI4_DATA_WIDTH-1:0] get_8byte_byteswap(
      input logic [HACD_AXI4_DATA_WIDTH-1:0] d);
    logic [HACD_AXI4_DATA_WIDTH-1:0] o;
    o = '0;
    for (int k = 0; k < int'(HACD_AXI4_DATA_WIDTH / 64); k++) begin
      for (int b = 0; b < 8; b++) begin
        o[64*k + 8*b +: 8] = d[64*k + 8*(7-b) +: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/hawk_att_lkup_rsp.sv
// ATT lookup engine: turns an HPPA lookup into a single-beat AXI read of the ATT,
// decodes the addressed entry and returns a registered translation response.
module hawk_att_lkup_rsp
  import hacd_pkg::*;
#(
  parameter logic [63:0] ATT_BASE  = HAWK_ATT_START,
  parameter logic [63:0] HPPA_BASE = HPPA_BASE_ADDR,
  parameter int unsigned ENTRY_CNT = ATT_ENTRY_CNT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  att_lkup_reqpkt_t lkup_req_i,
  output logic             lkup_ready_o,
  output axi_rd_reqpkt_t   rd_req_o,
  input  axi_rd_rdypkt_t   rd_rdy_i,
  input  axi_rd_resppkt_t  rd_resp_i,
  output trnsl_reqpkt_t    trnsl_o,
  output logic             trnsl_valid_o,
  output logic             lkup_err_o
);

  localparam int unsigned IDX_W = clogb2(ATT_ENTRY_MAX);

  typedef enum logic [1:0] {StIdle, StAr, StR, StRsp} state_e;

  function automatic AttEntry slot_entry(input logic [HACD_AXI4_DATA_WIDTH-1:0] line,
                                         input logic [2:0] slot);
    return AttEntry'(line[{slot, 6'b0} +: 64]);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? 8'hFF : c + 8'd1;
  endfunction

  function automatic trnsl_reqpkt_t err_rsp();
    trnsl_reqpkt_t p;
    p.allow_access = 1'b0;
    p.sts          = STS_DALLOC;
    p.ppa          = '0;
    p.zpd_update   = 1'b0;
    p.zpd_cnt      = 8'h00;
    return p;
  endfunction

  state_e              r_state;
  logic [63:0]         r_addr;
  logic                r_arvalid;
  logic                r_rready;
  logic [2:0]          r_slot;
  logic                r_zero;
  trnsl_reqpkt_t       r_trnsl;
  logic                r_valid;
  logic                r_err;

  logic [HACD_AXI4_ADDR_WIDTH-13:0] w_hppa_off;
  logic [IDX_W-1:0]                 w_idx;
  logic                             w_in_range;
  logic [63:0]                      w_line_addr;
  logic [63:0]                      w_ar_addr;
  logic [HACD_AXI4_DATA_WIDTH-1:0]  w_line;
  AttEntry                          w_entry;
  trnsl_reqpkt_t                    w_ok_rsp;
  logic                             w_unused;

  // Index is truncated to the ATT capacity before the range check.
  assign w_hppa_off  = lkup_req_i.hppa - HPPA_BASE[63:12];
  assign w_idx       = w_hppa_off[IDX_W-1:0];
  assign w_in_range  = (32'(w_idx) < ENTRY_CNT);
  assign w_line_addr = ATT_BASE + {{(64-IDX_W-3){1'b0}}, w_idx, 3'b000};
  assign w_ar_addr   = {w_line_addr[63:6], 6'b0};

  assign w_line  = get_8byte_byteswap(rd_resp_i.rdata);
  assign w_entry = slot_entry(w_line, r_slot);

  always_comb begin
    w_ok_rsp              = '0;
    w_ok_rsp.sts          = w_entry.sts;
    w_ok_rsp.ppa          = {w_entry.way[51:0], 12'h000};
    w_ok_rsp.allow_access = (w_entry.sts == STS_UNCOMP);
    w_ok_rsp.zpd_update   = r_zero && (w_entry.sts == STS_UNCOMP);
    w_ok_rsp.zpd_cnt      = w_ok_rsp.zpd_update ? sat_inc(w_entry.zpd_cnt) : w_entry.zpd_cnt;
  end

  assign w_unused = ^{rd_resp_i.rlast, w_hppa_off[HACD_AXI4_ADDR_WIDTH-13:IDX_W],
                      w_entry.way[53:52], w_line_addr[5:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_slot    <= '0;
      r_zero    <= 1'b0;
      r_trnsl   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (lkup_req_i.lookup) begin
            r_slot <= w_idx[2:0];
            r_zero <= lkup_req_i.zeroBlkWr;
            if (w_in_range) begin
              r_addr    <= w_ar_addr;
              r_arvalid <= 1'b1;
              r_state   <= StAr;
            end else begin
              r_trnsl <= err_rsp();
              r_valid <= 1'b1;
              r_err   <= 1'b1;
              r_state <= StRsp;
            end
          end
        end
        StAr: begin
          if (rd_rdy_i.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StR;
          end
        end
        StR: begin
          if (rd_resp_i.rvalid) begin
            r_rready <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= StRsp;
            if (rd_resp_i.rresp != 2'b00) begin
              r_trnsl <= err_rsp();
              r_err   <= 1'b1;
            end else begin
              r_trnsl <= w_ok_rsp;
            end
          end
        end
        StRsp: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    rd_req_o         = '0;
    rd_req_o.addr    = r_addr;
    rd_req_o.arlen   = 8'h00;
    rd_req_o.arvalid = r_arvalid;
    rd_req_o.rready  = r_rready;
  end

  assign lkup_ready_o  = (r_state == StIdle);
  assign trnsl_o       = r_trnsl;
  assign trnsl_valid_o = r_valid;
  assign lkup_err_o    = r_err;

endmodule
